// File: rtl/rob_commit_if.sv
// Commit-side bundle between the ROB head, the register file, the store
// path to the memory controller and the front-end redirect.
interface rob_commit_if #(
  parameter int unsigned ROB_IDX_W = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32
);
  // ROB head entry
  logic                 head_valid;
  logic                 head_ready;
  logic [ROB_IDX_W-1:0] head_tag;
  logic [1:0]           head_kind;
  logic [4:0]           head_rd;
  logic [DATA_W-1:0]    head_value;
  logic [ADDR_W-1:0]    head_mem_addr;
  logic [1:0]           head_mem_size;
  logic                 head_mispredict;
  logic [ADDR_W-1:0]    head_target_pc;
  logic                 pop;
  // register file write port
  logic                 rf_we;
  logic [4:0]           rf_rd;
  logic [DATA_W-1:0]    rf_value;
  logic [ROB_IDX_W-1:0] rf_tag;
  // store path
  logic                 mem_req;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_data;
  logic [1:0]           mem_size;
  logic                 mem_gnt;
  logic                 mem_done;
  // redirect and statistics
  logic                 flush;
  logic [ADDR_W-1:0]    flush_pc;
  logic [31:0]          retired_cnt;

  // commit controller side
  modport master (
    input  head_valid, head_ready, head_tag, head_kind, head_rd, head_value,
           head_mem_addr, head_mem_size, head_mispredict, head_target_pc,
           mem_gnt, mem_done,
    output pop, rf_we, rf_rd, rf_value, rf_tag,
           mem_req, mem_addr, mem_data, mem_size,
           flush, flush_pc, retired_cnt
  );

  // ROB / regfile / memory side
  modport slave (
    output head_valid, head_ready, head_tag, head_kind, head_rd, head_value,
           head_mem_addr, head_mem_size, head_mispredict, head_target_pc,
           mem_gnt, mem_done,
    input  pop, rf_we, rf_rd, rf_value, rf_tag,
           mem_req, mem_addr, mem_data, mem_size,
           flush, flush_pc, retired_cnt
  );
endinterface

// File: rtl/rob_commit_ctrl.sv
// In-order commit sequencer: retires the ROB head one entry at a time,
// writes register results, runs the store handshake and raises redirects.
module rob_commit_ctrl #(
  parameter int unsigned ROB_IDX_W = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  rob_commit_if.master bus
);
  localparam logic [1:0] KIND_REG   = 2'b00;
  localparam logic [1:0] KIND_STORE = 2'b01;
  localparam logic [1:0] KIND_BR    = 2'b10;
  localparam logic [1:0] KIND_JMP   = 2'b11;

  typedef enum logic [1:0] {COMMIT, ST_REQ, ST_WAIT, FLUSH} state_t;

  state_t               state_q, state_d;
  logic                 pop_q, pop_d, rf_we_q, rf_we_d, flush_q, flush_d;
  logic                 mem_req_q, mem_req_d;
  logic [4:0]           rf_rd_q, rf_rd_d;
  logic [DATA_W-1:0]    rf_value_q, rf_value_d, mem_data_q, mem_data_d;
  logic [ROB_IDX_W-1:0] rf_tag_q, rf_tag_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d, flush_pc_q, flush_pc_d;
  logic [1:0]           mem_size_q, mem_size_d;
  logic [31:0]          cnt_q, cnt_d;
  // gnt/done seen during a stall are remembered so the handshake is not lost
  logic                 gnt_seen_q, gnt_seen_d, done_seen_q, done_seen_d;
  logic                 gnt_now, done_now;

  // Next-state and next-output decision
  always_comb begin
    state_d     = state_q;
    pop_d       = 1'b0;
    rf_we_d     = 1'b0;
    flush_d     = 1'b0;
    mem_req_d   = mem_req_q;
    rf_rd_d     = rf_rd_q;
    rf_value_d  = rf_value_q;
    rf_tag_d    = rf_tag_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_size_d  = mem_size_q;
    flush_pc_d  = flush_pc_q;
    gnt_now     = gnt_seen_q | (bus.mem_gnt & mem_req_q);
    done_now    = done_seen_q |
                  (bus.mem_done & ((state_q == ST_REQ) || (state_q == ST_WAIT)));
    gnt_seen_d  = gnt_now;
    done_seen_d = done_now;

    if (rdy) begin
      case (state_q)
        COMMIT: begin
          if (bus.head_valid && bus.head_ready && !pop_q) begin
            case (bus.head_kind)
              KIND_STORE: begin
                mem_req_d   = 1'b1;
                mem_addr_d  = bus.head_mem_addr;
                mem_data_d  = bus.head_value;
                mem_size_d  = bus.head_mem_size;
                gnt_seen_d  = 1'b0;
                done_seen_d = 1'b0;
                state_d     = ST_REQ;
              end
              default: begin
                pop_d = 1'b1;
                if (bus.head_kind != KIND_BR) begin
                  rf_we_d    = (bus.head_rd != 5'd0);
                  rf_rd_d    = bus.head_rd;
                  rf_value_d = bus.head_value;
                  rf_tag_d   = bus.head_tag;
                end
                if ((bus.head_kind == KIND_BR || bus.head_kind == KIND_JMP) &&
                    bus.head_mispredict) begin
                  flush_d    = 1'b1;
                  flush_pc_d = bus.head_target_pc;
                  state_d    = FLUSH;
                end
              end
            endcase
          end
        end
        ST_REQ: begin
          if (gnt_now) begin
            mem_req_d = 1'b0;
            if (done_now) begin
              pop_d       = 1'b1;
              gnt_seen_d  = 1'b0;
              done_seen_d = 1'b0;
              state_d     = COMMIT;
            end else begin
              state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (done_now) begin
            pop_d       = 1'b1;
            gnt_seen_d  = 1'b0;
            done_seen_d = 1'b0;
            state_d     = COMMIT;
          end
        end
        FLUSH:   state_d = COMMIT;
        default: state_d = COMMIT;
      endcase
    end

    cnt_d = cnt_q + 32'(pop_d);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COMMIT;
      pop_q       <= 1'b0;
      rf_we_q     <= 1'b0;
      flush_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      rf_rd_q     <= '0;
      rf_value_q  <= '0;
      rf_tag_q    <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_size_q  <= '0;
      flush_pc_q  <= '0;
      cnt_q       <= '0;
      gnt_seen_q  <= 1'b0;
      done_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pop_q       <= pop_d;
      rf_we_q     <= rf_we_d;
      flush_q     <= flush_d;
      mem_req_q   <= mem_req_d;
      rf_rd_q     <= rf_rd_d;
      rf_value_q  <= rf_value_d;
      rf_tag_q    <= rf_tag_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_size_q  <= mem_size_d;
      flush_pc_q  <= flush_pc_d;
      cnt_q       <= cnt_d;
      gnt_seen_q  <= gnt_seen_d;
      done_seen_q <= done_seen_d;
    end
  end

  assign bus.pop         = pop_q;
  assign bus.rf_we       = rf_we_q;
  assign bus.rf_rd       = rf_rd_q;
  assign bus.rf_value    = rf_value_q;
  assign bus.rf_tag      = rf_tag_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_data    = mem_data_q;
  assign bus.mem_size    = mem_size_q;
  assign bus.flush       = flush_q;
  assign bus.flush_pc    = flush_pc_q;
  assign bus.retired_cnt = cnt_q;
endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl with hand-computed expectations.
module tb_rob_commit_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  rob_commit_if #(.ROB_IDX_W(4), .DATA_W(32), .ADDR_W(32)) bus ();

  rob_commit_ctrl #(.ROB_IDX_W(4), .DATA_W(32), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus.master)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one clock and settle past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_head(input logic [1:0] kind, input logic [4:0] rd,
                          input logic [31:0] value, input logic [3:0] tag,
                          input logic [31:0] addr, input logic [1:0] size,
                          input logic mis, input logic [31:0] tgt);
    bus.head_valid      = 1'b1;
    bus.head_ready      = 1'b1;
    bus.head_kind       = kind;
    bus.head_rd         = rd;
    bus.head_value      = value;
    bus.head_tag        = tag;
    bus.head_mem_addr   = addr;
    bus.head_mem_size   = size;
    bus.head_mispredict = mis;
    bus.head_target_pc  = tgt;
  endtask

  task automatic check_mem(input string tag, input logic [31:0] addr,
                           input logic [31:0] data, input logic [1:0] size);
    check({tag, "_req"},  64'(bus.mem_req),  64'd1);
    check({tag, "_addr"}, 64'(bus.mem_addr), 64'(addr));
    check({tag, "_data"}, 64'(bus.mem_data), 64'(data));
    check({tag, "_size"}, 64'(bus.mem_size), 64'(size));
  endtask

  initial begin
    int pops;
    rst = 1'b1;
    rdy = 1'b1;
    bus.head_valid = 1'b0; bus.head_ready = 1'b0; bus.head_tag = '0;
    bus.head_kind = '0; bus.head_rd = '0; bus.head_value = '0;
    bus.head_mem_addr = '0; bus.head_mem_size = '0; bus.head_mispredict = 1'b0;
    bus.head_target_pc = '0; bus.mem_gnt = 1'b0; bus.mem_done = 1'b0;

    // reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_pop", 64'(bus.pop), 64'd0);
    check("rst_rf_we", 64'(bus.rf_we), 64'd0);
    check("rst_mem_req", 64'(bus.mem_req), 64'd0);
    check("rst_flush", 64'(bus.flush), 64'd0);
    check("rst_rf_value", 64'(bus.rf_value), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_cnt", 64'(bus.retired_cnt), 64'd0);

    // idle: empty ROB for 10 cycles
    pops = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      pops += int'(bus.pop);
    end
    check("idle_pops", 64'(pops), 64'd0);
    check("idle_cnt", 64'(bus.retired_cnt), 64'd0);

    // back-to-back reg writes: one commit every second cycle
    set_head(2'b00, 5'd5, 32'h1234, 4'd3, 32'h0, 2'b00, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("b2b_pop%0d", i), 64'(bus.pop), 64'((i % 2) == 0));
      check($sformatf("b2b_we%0d", i), 64'(bus.rf_we), 64'((i % 2) == 0));
    end
    check("b2b_rd", 64'(bus.rf_rd), 64'd5);
    check("b2b_value", 64'(bus.rf_value), 64'h1234);
    check("b2b_tag", 64'(bus.rf_tag), 64'd3);
    check("b2b_cnt", 64'(bus.retired_cnt), 64'd3);

    // rd = 0: pop without register write
    bus.head_rd = 5'd0;
    tick();
    check("rd0_pop", 64'(bus.pop), 64'd1);
    check("rd0_we", 64'(bus.rf_we), 64'd0);
    check("rd0_cnt", 64'(bus.retired_cnt), 64'd4);
    bus.head_valid = 1'b0;
    tick();
    check("rd0_pop_after", 64'(bus.pop), 64'd0);

    // store: gnt in the 4th request cycle, done two cycles later
    set_head(2'b01, 5'd0, 32'hDEADBEEF, 4'd4, 32'h1000, 2'b10, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_mem($sformatf("st_c%0d", i), 32'h1000, 32'hDEADBEEF, 2'b10);
      check($sformatf("st_pop%0d", i), 64'(bus.pop), 64'd0);
      bus.head_valid = 1'b0;
    end
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    check("st_req_drop", 64'(bus.mem_req), 64'd0);
    check("st_wait_pop", 64'(bus.pop), 64'd0);
    tick();
    check("st_wait_pop2", 64'(bus.pop), 64'd0);
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    check("st_done_pop", 64'(bus.pop), 64'd1);
    check("st_done_cnt", 64'(bus.retired_cnt), 64'd5);
    tick();
    check("st_pop_once", 64'(bus.pop), 64'd0);

    // store with gnt and done together
    set_head(2'b01, 5'd0, 32'h55AA, 4'd5, 32'h2000, 2'b00, 1'b0, 32'h0);
    tick();
    check_mem("st2", 32'h2000, 32'h55AA, 2'b00);
    bus.head_valid = 1'b0;
    bus.mem_gnt = 1'b1;
    bus.mem_done = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    bus.mem_done = 1'b0;
    check("st2_req_drop", 64'(bus.mem_req), 64'd0);
    check("st2_pop", 64'(bus.pop), 64'd1);
    check("st2_cnt", 64'(bus.retired_cnt), 64'd6);
    tick();
    check("st2_pop_once", 64'(bus.pop), 64'd0);

    // mispredicted jump: pop, rf write and flush together
    set_head(2'b11, 5'd1, 32'h104, 4'd6, 32'h0, 2'b00, 1'b1, 32'h200);
    tick();
    check("mp_pop", 64'(bus.pop), 64'd1);
    check("mp_we", 64'(bus.rf_we), 64'd1);
    check("mp_rd", 64'(bus.rf_rd), 64'd1);
    check("mp_value", 64'(bus.rf_value), 64'h104);
    check("mp_flush", 64'(bus.flush), 64'd1);
    check("mp_flush_pc", 64'(bus.flush_pc), 64'h200);
    check("mp_cnt", 64'(bus.retired_cnt), 64'd7);
    tick();
    check("fl_pop", 64'(bus.pop), 64'd0);
    check("fl_flush", 64'(bus.flush), 64'd0);
    check("fl_we", 64'(bus.rf_we), 64'd0);
    bus.head_valid = 1'b0;
    tick();
    check("fl_after_pop", 64'(bus.pop), 64'd0);
    check("fl_after_cnt", 64'(bus.retired_cnt), 64'd7);

    // gnt while no request is pending must be ignored
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    set_head(2'b01, 5'd0, 32'hCAFEF00D, 4'd7, 32'h3000, 2'b01, 1'b0, 32'h0);
    tick();
    bus.head_valid = 1'b0;
    check_mem("stl_c0", 32'h3000, 32'hCAFEF00D, 2'b01);
    tick();
    check_mem("stl_c1", 32'h3000, 32'hCAFEF00D, 2'b01);

    // rdy stall during ST_REQ: request and fields hold, gnt remembered
    rdy = 1'b0;
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    check_mem("stl_s0", 32'h3000, 32'hCAFEF00D, 2'b01);
    tick();
    check_mem("stl_s1", 32'h3000, 32'hCAFEF00D, 2'b01);
    check("stl_s1_pop", 64'(bus.pop), 64'd0);
    rdy = 1'b1;
    tick();
    check("stl_req_drop", 64'(bus.mem_req), 64'd0);
    check("stl_wait_pop", 64'(bus.pop), 64'd0);

    // done arrives while stalled: pop deferred to the first rdy cycle
    rdy = 1'b0;
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    check("stl_d0_pop", 64'(bus.pop), 64'd0);
    tick();
    check("stl_d1_pop", 64'(bus.pop), 64'd0);
    check("stl_d1_cnt", 64'(bus.retired_cnt), 64'd7);
    rdy = 1'b1;
    tick();
    check("stl_pop", 64'(bus.pop), 64'd1);
    check("stl_cnt", 64'(bus.retired_cnt), 64'd8);
    tick();
    check("stl_pop_once", 64'(bus.pop), 64'd0);
    check("stl_cnt_hold", 64'(bus.retired_cnt), 64'd8);

    // reset in the middle of a store (ST_WAIT)
    set_head(2'b01, 5'd0, 32'h77, 4'd8, 32'h4000, 2'b10, 1'b0, 32'h0);
    tick();
    bus.head_valid = 1'b0;
    check_mem("rs_req", 32'h4000, 32'h77, 2'b10);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    check("rs_wait_req", 64'(bus.mem_req), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("rs_async_cnt", 64'(bus.retired_cnt), 64'd0);
    check("rs_async_req", 64'(bus.mem_req), 64'd0);
    check("rs_async_addr", 64'(bus.mem_addr), 64'd0);
    tick();
    rst = 1'b0;
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    check("rs_done_pop", 64'(bus.pop), 64'd0);
    tick();
    check("rs_done_pop2", 64'(bus.pop), 64'd0);
    check("rs_cnt", 64'(bus.retired_cnt), 64'd0);

    // back in COMMIT: a plain reg write retires immediately
    set_head(2'b00, 5'd9, 32'hABCD, 4'd9, 32'h0, 2'b00, 1'b0, 32'h0);
    tick();
    bus.head_valid = 1'b0;
    check("rs_commit_pop", 64'(bus.pop), 64'd1);
    check("rs_commit_rd", 64'(bus.rf_rd), 64'd9);
    check("rs_commit_cnt", 64'(bus.retired_cnt), 64'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
